// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo
//   Byte FIFO that feeds a UART transmitter. Producers push one byte per
//   clock with a write strobe. A small feeder FSM pops one byte at a time
//   and hands it to the transmitter over its DV/Active/Done handshake.
//
// Ports
//   i_Clock, i_Reset        : clock, synchronous active-high reset
//   i_Wr_DV, i_Wr_Byte      : write strobe and data
//   o_Full, o_Empty, o_Count: fill status (combinational from registers)
//   o_Overflow              : one-clock pulse after a dropped write
//   o_Busy                  : FIFO non-empty or feeder not idle
//   o_TX_DV, o_TX_Byte      : request and byte to the transmitter
//   i_TX_Active, i_TX_Done  : transmitter status
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_DV,
    input  logic [7:0]        i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Busy,
    output logic              o_TX_DV,
    output logic [7:0]        o_TX_Byte,
    input  logic              i_TX_Active,
    input  logic              i_TX_Done
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_WAIT_ACT,
        S_WAIT_DONE,
        S_WAIT_CLR
    } state_t;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    state_t            state_q, state_d;

    logic full, empty, wr_en, pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    // Full is judged on the registered count, so a pop on the same edge
    // does not rescue a write that arrives while full.
    assign wr_en = i_Wr_DV && !full;
    assign pop   = (state_q == S_IDLE) && !empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = i_Wr_DV && full;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        state_d   = state_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end

        if (wr_en && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        case (state_q)
            // Transmitter has no reset: wait for it to go quiet before
            // issuing anything, otherwise a DV could land mid-frame.
            S_SYNC: begin
                if (!i_TX_Active && !i_TX_Done) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (pop) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = mem_q[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
                    state_d   = S_WAIT_ACT;
                end
            end
            S_WAIT_ACT: begin
                if (i_TX_Active) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (i_TX_Done) begin
                    state_d = S_WAIT_CLR;
                end
            end
            // Done can be held for many clocks; wait for it to drop so the
            // next DV reaches a transmitter that is back in idle.
            S_WAIT_CLR: begin
                if (!i_TX_Done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    // Storage is not reset; stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_Wr_Byte;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            state_q   <= S_SYNC;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            state_q   <= state_d;
        end
    end

    assign o_Full     = full;
    assign o_Empty    = empty;
    assign o_Count    = count_q;
    assign o_Overflow = ovf_q;
    assign o_Busy     = !empty || (state_q != S_IDLE);
    assign o_TX_DV    = tx_dv_q;
    assign o_TX_Byte  = tx_byte_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered feeder sitting directly upstream of the UART transmitter.
- Accepts bytes from the design through a single-cycle write strobe and stores them in a circular FIFO.
- Hands bytes one at a time to the transmitter using its DV/Active/Done handshake, so producers never wait on serial timing.
- Reports fill level, full/empty state and dropped writes.

Parameters:
- DEPTH, 16, number of FIFO entries; power of 2, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- i_Clock  in  1  system clock, all logic on posedge.
- i_Reset  in  1  synchronous active-high reset.
- i_Wr_DV  in  1  write strobe; one byte per clock while high.
- i_Wr_Byte  in  8  byte to enqueue, sampled when i_Wr_DV=1.
- o_Full  out  1  count==DEPTH.
- o_Empty  out  1  count==0.
- o_Count  out  ADDR_W+1  bytes currently stored (0..DEPTH).
- o_Overflow  out  1  one-clock pulse when a write is dropped.
- o_Busy  out  1  FIFO non-empty or feeder FSM not in IDLE.
- o_TX_DV  out  1  one-clock request to transmitter.
- o_TX_Byte  out  8  byte for transmitter; valid while o_TX_DV=1, held afterwards.
- i_TX_Active  in  1  transmitter frame in progress.
- i_TX_Done  in  1  transmitter done; may stay high for many clocks.

Behaviour:
- Clock and reset: one clock, i_Clock. Reset i_Reset is synchronous and active-high.
- Reset values:
  - Pointers 0, count 0, so o_Empty=1, o_Full=0, o_Count=0.
  - o_Overflow=0, o_TX_DV=0, o_TX_Byte=0.
  - FSM enters SYNC; o_Busy=1 while in SYNC.
  - Memory contents are not reset.
- Write:
  - Accepted iff i_Wr_DV=1 and registered count<DEPTH at that edge.
  - Stores to mem[wr_ptr]; wr_ptr wraps DEPTH-1 -> 0.
  - A write while full is dropped, even if a pop occurs on the same clock. It raises o_Overflow for exactly one clock (registered, next cycle).
- Pop: occurs only in IDLE when count>0. Same edge: o_TX_DV<=1, o_TX_Byte<=mem[rd_ptr], rd_ptr wraps DEPTH-1 -> 0.
- Simultaneous accepted write and pop: count unchanged, both pointers advance.
- Count arithmetic is ADDR_W+1 bits; it never exceeds DEPTH and never goes below 0.
- Read-during-write on the same address when count==0 is impossible, because a pop requires count>0 at the edge.
- Feeder FSM:
  - SYNC: wait until i_TX_Active=0 and i_TX_Done=0, then go to IDLE. Covers reset asserted mid-frame; the transmitter has no reset.
  - IDLE: if count>0, pop as above and go to WAIT_ACT. Otherwise stay; o_TX_DV=0.
  - WAIT_ACT: o_TX_DV<=0. Wait for i_TX_Active=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for i_TX_Done=1, then go to WAIT_CLR.
  - WAIT_CLR: wait for i_TX_Done=0, then go to IDLE. Done clears only once the transmitter is back in its idle state, so the next DV is never lost.
- Latency: with the FIFO empty and the FSM in IDLE, a write on edge k gives count=1 after edge k and o_TX_DV=1 after edge k+1. That is 2 clocks from write to DV.
- o_TX_DV never asserts outside IDLE->WAIT_ACT, and never on consecutive clocks.
- Reset mid-operation:
  - Stored bytes are discarded.
  - A byte already handed to the transmitter still completes on the line.
  - The feeder waits in SYNC until the transmitter is quiet.
- o_Full, o_Empty, o_Count and o_Busy are combinational from registers; no combinational input-to-output paths.

Test Plan:
- Reset then a single write of 0xA5, with the transmitter at CLKS_PER_BIT=4 -> o_TX_DV high exactly 2 clocks after the write, for 1 clock, with o_TX_Byte=0xA5. Line shows 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1. o_Busy falls after Done clears.
- Burst of 3 writes (0x11,0x22,0x33) on consecutive clocks -> o_Count peaks at 2 (first byte popped immediately). Three frames leave in order 0x11,0x22,0x33, with exactly one DV per frame and no DV while Active or Done is high.
- DEPTH=4: write 0x01..0x06 back-to-back with the feeder blocked (i_TX_Active held 0 after the first DV) -> first byte popped, bytes 2..5 stored. o_Full=1 and o_Count=4. The 6th write is dropped with o_Overflow high for 1 clock.
- Full FIFO: simultaneous write and pop -> write dropped, o_Overflow pulses, count goes 4 -> 3.
- Wrap-around with DEPTH=4: 10 bytes 0x40..0x49 streamed through -> all 10 are transmitted in order and the pointers wrap twice.
- Assert i_Reset for 1 clock mid-frame with 2 bytes queued -> count=0 and o_Empty=1. The in-flight frame finishes on the line, no DV is issued until Active=0 and Done=0, and the next write transmits correctly.
